keypad_scanner: RTL and testbench

//  Input-side counterpart of the multiplexed 7-seg driver: scans a 4x4 active-low
//  key matrix, synchronises and debounces it, and emits one-cycle key events.
//  An entry accumulator turns digit keys plus ENTER into a 0..99 binary setting
//  (water level / cycle times) for the controller FSM.

---
 rtl/keypad_scanner.sv | 184 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner with debounce, one-cycle key events and a two-digit
// entry accumulator. Define KEY_REPEAT_EN to enable auto-repeat while a key stays held.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 4096,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 64,
    parameter int unsigned REPEAT_RATE    = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_row_n,
    output logic [3:0] o_col_n,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_held,
    output logic [7:0] o_value,
    output logic       o_value_valid
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_SCANS);
    // Candidate/stable encoding: {present, code}; NONE has present=0.
    localparam logic [4:0] NONE = 5'd0;

    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_sync;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_col;
    logic [15:0]   r_snap;
    logic [4:0]    r_last;
    logic [4:0]    r_stable;
    logic [DW-1:0] r_db_cnt;
    logic          r_evt_pend;
    logic [3:0]    r_evt_code;
    logic [3:0]    r_tens;
    logic [3:0]    r_units;

    logic          w_tick;
    logic          w_scan_done;
    logic [15:0]   w_snap_next;
    logic [4:0]    w_nlow;
    logic [3:0]    w_code;
    logic [4:0]    w_cand;
    logic [DW-1:0] w_db_next;
    logic          w_accept;
    logic          w_repeat;
    logic [7:0]    w_value;

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_scan_done = w_tick && (r_col == 2'd3);
    assign o_key_held  = r_stable[4];
    assign w_value     = {1'b0, r_tens, 3'b000} + {3'b000, r_tens, 1'b0} + {4'b0000, r_units};

    always_comb begin
        o_col_n = 4'b1110;
        unique case (r_col)
            2'd0: o_col_n = 4'b1110;
            2'd1: o_col_n = 4'b1101;
            2'd2: o_col_n = 4'b1011;
            2'd3: o_col_n = 4'b0111;
        endcase
    end

    // Snapshot including the column being sampled this tick; complete when r_col==3.
    always_comb begin
        w_snap_next = r_snap;
        for (int r = 0; r < 4; r++) begin
            w_snap_next[{r[1:0], r_col}] = r_row_sync[r];
        end
    end

    always_comb begin
        w_nlow = 5'd0;
        w_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!w_snap_next[i]) begin
                w_nlow = w_nlow + 5'd1;
                w_code = i[3:0];
            end
        end
        w_cand = (w_nlow == 5'd1) ? {1'b1, w_code} : NONE;
    end

    always_comb begin
        if (w_cand != r_last) begin
            w_db_next = DW'(1);
        end else if (r_db_cnt < DB_MAX) begin
            w_db_next = r_db_cnt + DW'(1);
        end else begin
            w_db_next = r_db_cnt;
        end
    end

    assign w_accept = w_scan_done && (w_db_next >= DB_MAX) && (w_cand != r_stable);

`ifdef KEY_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_NEXT = RW'(REPEAT_DELAY + REPEAT_RATE);

    logic [RW-1:0] r_rep_cnt;
    logic [RW-1:0] w_rep_next;
    logic          w_rep_count;

    assign w_rep_next  = r_rep_cnt + RW'(1);
    assign w_rep_count = w_scan_done && !w_accept && r_stable[4] && (w_cand == r_stable);
    assign w_repeat    = w_rep_count && ((w_rep_next == REP_FIRST) || (w_rep_next == REP_NEXT));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rep_cnt <= '0;
        end else if (w_scan_done && (w_accept || !r_stable[4])) begin
            r_rep_cnt <= '0;
        end else if (w_rep_count) begin
            r_rep_cnt <= (w_rep_next == REP_NEXT) ? REP_FIRST : w_rep_next;
        end
    end
`else
    logic w_unused_repeat;
    assign w_unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE};
    assign w_repeat        = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_row_meta    <= 4'hf;
            r_row_sync    <= 4'hf;
            r_presc       <= '0;
            r_col         <= 2'd0;
            r_snap        <= 16'hffff;
            r_last        <= NONE;
            r_stable      <= NONE;
            r_db_cnt      <= '0;
            r_evt_pend    <= 1'b0;
            r_evt_code    <= 4'd0;
            r_tens        <= 4'd0;
            r_units       <= 4'd0;
            o_key_code    <= 4'd0;
            o_key_valid   <= 1'b0;
            o_value       <= 8'd0;
            o_value_valid <= 1'b0;
        end else begin
            r_row_meta <= i_row_n;
            r_row_sync <= r_row_meta;
            r_presc    <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_col  <= r_col + 2'd1;
                r_snap <= w_snap_next;
            end
            if (w_scan_done) begin
                r_last   <= w_cand;
                r_db_cnt <= w_db_next;
                if (w_accept) begin
                    r_stable <= w_cand;
                end
            end

            // Events fire only leaving NONE (or on repeat); key-to-key rollover is silent.
            r_evt_pend <= (w_accept && !r_stable[4] && w_cand[4]) || w_repeat;
            r_evt_code <= w_cand[3:0];
            o_key_valid <= r_evt_pend;
            if (r_evt_pend) begin
                o_key_code <= r_evt_code;
            end

            o_value_valid <= 1'b0;
            if (o_key_valid) begin
                if (o_key_code <= 4'd9) begin
                    r_tens  <= r_units;
                    r_units <= o_key_code;
                end else if (o_key_code == 4'd10) begin
                    o_value       <= w_value;
                    o_value_valid <= 1'b1;
                end else if (o_key_code == 4'd11) begin
                    r_tens  <= 4'd0;
                    r_units <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a key-matrix model drives rows from the column
// strobes; expected key/value events are queued and checked by an independent monitor.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV       = 4;
    localparam int unsigned DEBOUNCE_SCANS = 2;
    localparam int unsigned REPEAT_DELAY   = 4;
    localparam int unsigned REPEAT_RATE    = 2;

    typedef struct packed {
        logic       is_val;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keys;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [7:0]  value;
    logic        value_valid;

    exp_t q[$];
    exp_t m_e;
    exp_t m_got;
    int   n_checks = 0;
    int   n_fail = 0;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_RATE   (REPEAT_RATE)
    ) u_dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_row_n      (row_n),
        .o_col_n      (col_n),
        .o_key_code   (key_code),
        .o_key_valid  (key_valid),
        .o_key_held   (key_held),
        .o_value      (value),
        .o_value_valid(value_valid)
    );

    always #5 clk = ~clk;

    // A closed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_n = 4'hf;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
        end
    end

    always @(negedge clk) begin
        if (!reset && (key_valid || value_valid)) begin
            n_checks++;
            m_got.is_val = value_valid;
            m_got.data   = key_valid ? {4'd0, key_code} : value;
            if (key_valid && value_valid) begin
                n_fail++;
                $display("FAIL pulse_overlap: key_valid and value_valid both high, required exclusive");
            end else if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got is_val=%0d data=%0d, required no event",
                         m_got.is_val, m_got.data);
            end else begin
                m_e = q.pop_front();
                if (m_got !== m_e) begin
                    n_fail++;
                    $display("FAIL event: got is_val=%0d data=%0d, required is_val=%0d data=%0d",
                             m_got.is_val, m_got.data, m_e.is_val, m_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic exp_key(input int code);
        exp_t e;
        e.is_val = 1'b0;
        e.data   = 8'(code);
        q.push_back(e);
    endtask

    task automatic exp_val(input int v);
        exp_t e;
        e.is_val = 1'b1;
        e.data   = 8'(v);
        q.push_back(e);
    endtask

    // Returns at the negedge just after a column-3 sample (start of a new full scan).
    task automatic scan_end();
        int k;
        k = 0;
        while (col_n != 4'b0111 && k < 100) begin
            @(negedge clk);
            k++;
        end
        while (col_n != 4'b1110 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL scan_timeout: got col_n=%b, required scan wrap within 100 cycles", col_n);
        end
    endtask

    task automatic scans(input int n);
        for (int i = 0; i < n; i++) scan_end();
    endtask

    task automatic press(input int code, input int hold, input int gap);
        keys = 16'd1 << code;
        scans(hold);
        keys = 16'd0;
        scans(gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_n"}, 32'(col_n), 32'b1110);
        check({tag, "_key_code"}, 32'(key_code), 0);
        check({tag, "_key_valid"}, 32'(key_valid), 0);
        check({tag, "_key_held"}, 32'(key_held), 0);
        check({tag, "_value"}, 32'(value), 0);
        check({tag, "_value_valid"}, 32'(value_valid), 0);
    endtask

    initial begin
        reset = 1'b1;
        keys  = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");
        reset = 1'b0;
        scans(2);

        // Long hold of key 5, then release.
        exp_key(5);
`ifdef KEY_REPEAT_EN
        exp_key(5);
        exp_key(5);
        exp_key(5);
`endif
        keys = 16'd1 << 5;
        scans(1);
        check("hold5_held_scan1", 32'(key_held), 0);
        scans(1);
        check("hold5_held_scan2", 32'(key_held), 1);
        scans(8);
        keys = 16'd0;
        scans(1);
        check("hold5_held_rel1", 32'(key_held), 1);
        scans(1);
        check("hold5_held_rel2", 32'(key_held), 0);
        check("hold5_code", 32'(key_code), 5);

        // Bounce: single-scan press is rejected.
        keys = 16'd1 << 5;
        scans(1);
        keys = 16'd0;
        check("bounce_held_a", 32'(key_held), 0);
        scans(3);
        check("bounce_held_b", 32'(key_held), 0);

        // 4, 2, ENTER -> 42.
        exp_key(4);
        press(4, 3, 3);
        exp_key(2);
        press(2, 3, 3);
        exp_key(10);
        exp_val(42);
        press(10, 3, 3);
        check("entry_42", 32'(value), 42);

        // 7, CLEAR, ENTER -> 0.
        exp_key(7);
        press(7, 3, 3);
        exp_key(11);
        press(11, 3, 3);
        check("clear_keeps_value", 32'(value), 42);
        exp_key(10);
        exp_val(0);
        press(10, 3, 3);
        check("entry_0", 32'(value), 0);

        // Keys 3 and 6 together: ambiguous, never accepted.
        keys = (16'd1 << 3) | (16'd1 << 6);
        scans(2);
        check("dual_held_a", 32'(key_held), 0);
        scans(8);
        check("dual_held_b", 32'(key_held), 0);
        keys = 16'd0;
        scans(3);

        // Reset mid-scan while a key is held after an entry.
        exp_key(4);
        press(4, 3, 3);
        exp_key(2);
        press(2, 3, 3);
        exp_key(10);
        exp_val(42);
        press(10, 3, 3);
        check("pre_reset_value", 32'(value), 42);
        exp_key(9);
        keys = 16'd1 << 9;
        scans(3);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        keys = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        scans(4);
        // Digits were cleared by reset, so ENTER commits 0.
        exp_key(10);
        exp_val(0);
        press(10, 3, 3);

`ifdef KEY_REPEAT_EN
        for (int i = 0; i < 5; i++) exp_key(1);
        press(1, 12, 3);
`endif

        repeat (20) @(negedge clk);
        check("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
